// File: rtl/contatore_discendente.sv
// rtl/contatore_discendente.sv - programmable down-counter loaded via dav_/rfd handshake
module contatore_discendente #(
    parameter int N = 3
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         dav_,
    input  logic [N-1:0] valore,
    output logic         rfd,
    output logic [N-1:0] out,
    output logic         fine
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0] state;

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state <= S_IDLE;
            out   <= '0;
            rfd   <= 1'b1;
            fine  <= 1'b0;
        end else begin
            // fine is only raised on the COUNT->WAIT transition, so it lasts one clock
            fine <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!dav_) begin
                        out   <= valore;
                        rfd   <= 1'b0;
                        state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (out != '0) begin
                        out <= out - N'(1);
                    end else begin
                        fine  <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // re-arm only once the producer has released dav_
                    if (dav_) begin
                        rfd   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    out   <= '0;
                    rfd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_contatore_discendente.sv
// tb/tb_contatore_discendente.sv - directed self-checking bench for contatore_discendente
module tb_contatore_discendente;

    localparam int N = 3;

    logic         clock;
    logic         reset_;
    logic         dav_;
    logic [N-1:0] valore;
    logic         rfd;
    logic [N-1:0] out;
    logic         fine;

    int checks   = 0;
    int failures = 0;
    int fine_cnt = 0;

    contatore_discendente #(.N(N)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .dav_   (dav_),
        .valore (valore),
        .rfd    (rfd),
        .out    (out),
        .fine   (fine)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one rising edge and settle away from it
    task automatic step();
        @(posedge clock);
        #1;
        if (fine) fine_cnt++;
    endtask

    task automatic expect_state(input string tag, input int e_out, input int e_rfd, input int e_fine);
        check({tag, ".out"},  int'(out),  e_out);
        check({tag, ".rfd"},  int'(rfd),  e_rfd);
        check({tag, ".fine"}, int'(fine), e_fine);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset_ = 1'b0;
        dav_   = 1'b0;
        valore = 3'd5;

        // reset overrides an offered load
        step(); expect_state("rst1", 0, 1, 0);
        step(); expect_state("rst2", 0, 1, 0);
        reset_ = 1'b1;
        dav_   = 1'b1;
        step(); expect_state("idle", 0, 1, 0);

        // load 5
        dav_ = 1'b0; valore = 3'd5;
        step(); expect_state("l5_k", 5, 0, 0);
        dav_ = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(); expect_state($sformatf("l5_k%0d", i), 5 - i, 0, 0);
        end
        step(); expect_state("l5_fine", 0, 0, 1);
        step(); expect_state("l5_rearm", 0, 1, 0);

        // load 0
        dav_ = 1'b0; valore = 3'd0;
        step(); expect_state("l0_k", 0, 0, 0);
        dav_ = 1'b1;
        step(); expect_state("l0_fine", 0, 0, 1);
        step(); expect_state("l0_rearm", 0, 1, 0);

        // slow producer, full-range load 7
        dav_ = 1'b0; valore = 3'd7;
        step(); expect_state("l7_k", 7, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            step(); expect_state($sformatf("l7_k%0d", i), 7 - i, 0, 0);
        end
        step(); expect_state("l7_fine", 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(); expect_state($sformatf("l7_wait%0d", i), 0, 0, 0);
        end
        dav_ = 1'b1;
        step(); expect_state("l7_rearm", 0, 1, 0);
        step(); expect_state("l7_noreload", 0, 1, 0);

        // reset mid-count
        dav_ = 1'b0; valore = 3'd6;
        step(); expect_state("l6_k", 6, 0, 0);
        dav_ = 1'b1;
        step(); step(); step();
        expect_state("l6_at3", 3, 0, 0);
        reset_ = 1'b0;
        step(); expect_state("l6_rst", 0, 1, 0);
        reset_ = 1'b1;
        step(); expect_state("l6_idle", 0, 1, 0);
        dav_ = 1'b0; valore = 3'd2;
        step(); expect_state("l2_k", 2, 0, 0);
        dav_ = 1'b1;
        step(); expect_state("l2_k1", 1, 0, 0);
        step(); expect_state("l2_k2", 0, 0, 0);
        step(); expect_state("l2_fine", 0, 0, 1);
        step(); expect_state("l2_rearm", 0, 1, 0);

        // dav_ and valore ignored while counting
        dav_ = 1'b0; valore = 3'd4;
        step(); expect_state("l4_k", 4, 0, 0);
        fine_cnt = 0;
        valore = 3'd7;
        dav_ = 1'b1; step(); expect_state("l4_k1", 3, 0, 0);
        dav_ = 1'b0; step(); expect_state("l4_k2", 2, 0, 0);
        dav_ = 1'b1; step(); expect_state("l4_k3", 1, 0, 0);
        dav_ = 1'b0; step(); expect_state("l4_k4", 0, 0, 0);
        dav_ = 1'b1; step(); expect_state("l4_fine", 0, 0, 1);
        step(); expect_state("l4_rearm", 0, 1, 0);
        step(); expect_state("l4_idle", 0, 1, 0);
        check("l4_fine_pulses", fine_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
